// File: rtl/store_queue_unit_pkg.sv
// store_pkg: shared constants, size decode and queue entry type for the store queue unit.
// Entry fields are sized for the widest datapath; narrower builds zero-extend into them.
package store_pkg;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;
   localparam logic [2:0] F3_SD = 3'b011;
   localparam int XLEN_MAX = 64;

   typedef enum logic [2:0] {SZ_B, SZ_H, SZ_W, SZ_D, SZ_BAD} size_e;
   typedef enum logic {IDLE, REQ} state_e;

   typedef struct packed {
      logic [XLEN_MAX-1:0]   addr;
      logic [XLEN_MAX-1:0]   data;
      logic [XLEN_MAX/8-1:0] strb;
   } store_entry_t;

   function automatic size_e size_of(input logic [2:0] f3, input logic xlen64);
      return f3 == F3_SB ? SZ_B :
             f3 == F3_SH ? SZ_H :
             f3 == F3_SW ? SZ_W :
             (f3 == F3_SD && xlen64) ? SZ_D : SZ_BAD;
   endfunction
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: combinational byte-lane alignment, strobe generation and
// misaligned/illegal-size detection for one store.
module store_lane_align
   import store_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int STRB_W = XLEN / 8,
   localparam int OW = $clog2(STRB_W)
) (
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   rs2,
   output logic [XLEN-1:0]   aligned_addr,
   output logic [XLEN-1:0]   wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              misaligned,
   output logic              illegal
);
   size_e sz;
   logic [OW-1:0] off;
   logic [OW-1:0] am;
   logic [STRB_W-1:0] mask;

   // am holds the offset bits that must be zero for the access size
   always_comb begin
      sz = size_of(funct3, XLEN == 64);
      off = addr[OW-1:0];
      mask = sz == SZ_B ? STRB_W'(1) :
             sz == SZ_H ? STRB_W'(3) :
             sz == SZ_W ? STRB_W'(15) :
             sz == SZ_D ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
      am = sz == SZ_H ? OW'(1) :
           sz == SZ_W ? OW'(3) :
           sz == SZ_D ? OW'(7) : {OW{1'b0}};
      illegal = sz == SZ_BAD;
      misaligned = |(off & am);
      wstrb = mask << off;
      wdata = rs2 << {off, 3'b000};
      aligned_addr = addr & ~XLEN'(STRB_W - 1);
   end
endmodule

// File: rtl/store_queue_unit.sv
// store_queue_unit: S-type store address/alignment plus an in-order DEPTH-entry queue drained over req/ack.
// Define STORE_FWD_EN to add the ld_addr/ld_conflict load-conflict probe.
module store_queue_unit
   import store_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int DEPTH = 4,
   localparam int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [11:0]       imm,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   rs2,
   output logic              err_valid,
   output logic [XLEN-1:0]   err_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic              empty
`ifdef STORE_FWD_EN
   ,
   input  logic [XLEN-1:0]   ld_addr,
   output logic              ld_conflict
`endif
);
   localparam int AW = $clog2(DEPTH);

   store_entry_t q [DEPTH];
   store_entry_t head;
   state_e st, st_nx;
   logic [AW-1:0] wp, rp, src;
   logic [AW:0] cnt;
   logic acc, is_store, bad, enq, retire, load, mis, ill;
   logic [XLEN-1:0] ea, al_addr, al_data;
   logic [STRB_W-1:0] al_strb;
   logic unused_hi;

   assign in_ready = cnt < (AW+1)'(DEPTH);
   assign acc = in_valid & in_ready;
   assign is_store = opcode == OPC_STORE;
   assign ea = rs1 + XLEN'($signed(imm));
   assign bad = acc & is_store & (mis | ill);
   assign enq = acc & is_store & ~mis & ~ill;

   store_lane_align #(.XLEN(XLEN)) u_align (
      .funct3      (funct3),
      .addr        (ea),
      .rs2         (rs2),
      .aligned_addr(al_addr),
      .wdata       (al_data),
      .wstrb       (al_strb),
      .misaligned  (mis),
      .illegal     (ill)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else st <= st_nx;

   always_comb begin
      st_nx = st == IDLE ? (cnt != 0 ? REQ : IDLE) : ((mem_ack && cnt <= 1) ? IDLE : REQ);
   end

   // The in-flight entry stays counted until acked; src picks the entry behind it on back-to-back drains
   always_comb begin
      retire = (st == REQ) & mem_ack;
      load = st == IDLE ? cnt != 0 : mem_ack & (cnt > 1);
      src = st == IDLE ? rp : rp + AW'(1);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         head <= '0;
         err_valid <= 1'b0;
         err_addr <= '0;
      end else begin
         wp <= wp + AW'(enq);
         rp <= rp + AW'(retire);
         cnt <= cnt + (AW+1)'(enq) - (AW+1)'(retire);
         if (load) head <= q[src];
         err_valid <= bad;
         if (bad) err_addr <= ea;
      end

   always_ff @(posedge clk)
      if (enq) q[wp] <= '{addr: XLEN_MAX'(al_addr), data: XLEN_MAX'(al_data), strb: (XLEN_MAX/8)'(al_strb)};

   assign mem_req = st == REQ;
   assign mem_addr = head.addr[XLEN-1:0];
   assign mem_wdata = head.data[XLEN-1:0];
   assign mem_wstrb = head.strb[STRB_W-1:0];
   assign empty = (cnt == 0) & (st == IDLE);
   assign unused_hi = ^{head.addr >> XLEN, head.data >> XLEN, head.strb >> STRB_W};

`ifdef STORE_FWD_EN
   logic [XLEN-1:0] ld_al;

   assign ld_al = ld_addr & ~XLEN'(STRB_W - 1);

   // The in-flight entry is still inside the valid window, so it is covered here too
   always_comb begin
      ld_conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if ({1'b0, AW'(i) - rp} < cnt && q[i].addr[XLEN-1:0] == ld_al) ld_conflict = 1'b1;
   end
`endif
endmodule

// File: tb/tb_store_queue_unit.sv
// tb_store_queue_unit: directed stimulus with a scoreboard of expected memory writes and error pulses.
module tb_store_queue_unit;
   import store_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } mtx_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic mem_ack = 1'b0;
   logic [6:0] opcode = OPC_STORE;
   logic [2:0] funct3 = '0;
   logic [11:0] imm = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic in_ready, err_valid, mem_req, empty;
   logic [31:0] err_addr, mem_addr, mem_wdata;
   logic [3:0] mem_wstrb;
`ifdef STORE_FWD_EN
   logic [31:0] ld_addr = '0;
   logic ld_conflict;
`endif

   int total = 0;
   int bad = 0;
   mtx_t mq[$];
   logic [31:0] errq[$];

   store_queue_unit #(.XLEN(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .imm(imm), .rs1(rs1), .rs2(rs2),
      .err_valid(err_valid), .err_addr(err_addr),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .empty(empty)
`ifdef STORE_FWD_EN
      , .ld_addr(ld_addr), .ld_conflict(ld_conflict)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 1 = enqueued store, 2 = error, 3 = non-store opcode, 0 = no effect
   task automatic send(input logic [2:0] f3, input logic [31:0] r1, input logic [11:0] im,
                       input logic [31:0] r2, input int kind,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es);
      mtx_t m;
      opcode = kind == 3 ? 7'b0110011 : OPC_STORE;
      funct3 = f3;
      rs1 = r1;
      imm = im;
      rs2 = r2;
      in_valid = 1'b1;
      m.a = ea;
      m.d = ed;
      m.s = es;
      if (kind == 1) mq.push_back(m);
      if (kind == 2) errq.push_back(ea);
      for (int c = 0; c < 50 && !in_ready; c++) @(negedge clk);
      chk("send_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      for (int c = 0; c < 50 && !empty; c++) tick();
      chk("drain_empty", {31'b0, empty}, 32'd1);
   endtask

   // Monitor: every accepted memory write and every error pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (rst_n && mem_req && mem_ack) begin
         if (mq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_mem: got addr=%h want none", mem_addr);
         end else begin
            chk("mem_addr", mem_addr, mq[0].a);
            chk("mem_wdata", mem_wdata, mq[0].d);
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mq[0].s});
            void'(mq.pop_front());
         end
      end
      if (rst_n && err_valid) begin
         if (errq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_err: got addr=%h want none", err_addr);
         end else begin
            chk("err_addr", err_addr, errq[0]);
            void'(errq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // SB at offset 3 with request latency
      mem_ack = 1'b1;
      send(F3_SB, 32'h1000, 12'h003, 32'h0000_00AB, 1, 32'h1000, 32'hAB00_0000, 4'b1000);
      chk("sb_req_lat0", {31'b0, mem_req}, 32'd0);
      tick();
      chk("sb_req_lat1", {31'b0, mem_req}, 32'd1);
      tick();
      chk("sb_req_done", {31'b0, mem_req}, 32'd0);
      chk("sb_empty", {31'b0, empty}, 32'd1);

      // Misaligned SH: single error pulse, nothing queued
      send(F3_SH, 32'h1001, 12'h000, 32'h5555, 2, 32'h1001, 32'h0, 4'h0);
      chk("sh_err_pulse", {31'b0, err_valid}, 32'd1);
      chk("sh_err_req", {31'b0, mem_req}, 32'd0);
      chk("sh_err_empty", {31'b0, empty}, 32'd1);
      tick();
      chk("sh_err_single", {31'b0, err_valid}, 32'd0);
      chk("sh_err_req2", {31'b0, mem_req}, 32'd0);
      chk("sh_err_empty2", {31'b0, empty}, 32'd1);

      // Illegal sizes and a non-store opcode
      send(F3_SD, 32'h3000, 12'h000, 32'h1, 2, 32'h3000, 32'h0, 4'h0);
      tick();
      send(3'b101, 32'h3004, 12'h004, 32'h1, 2, 32'h3008, 32'h0, 4'h0);
      tick();
      send(F3_SW, 32'h4000, 12'h000, 32'h1, 3, 32'h0, 32'h0, 4'h0);
      chk("nonstore_err", {31'b0, err_valid}, 32'd0);
      chk("nonstore_empty", {31'b0, empty}, 32'd1);
      tick();
      chk("nonstore_req", {31'b0, mem_req}, 32'd0);

      // Negative immediate, lane shifts, truncation and address wrap
      send(F3_SW, 32'h2000, 12'hFFC, 32'hDEAD_BEEF, 1, 32'h1FFC, 32'hDEAD_BEEF, 4'b1111);
      send(F3_SH, 32'h0040, 12'h002, 32'h0000_1234, 1, 32'h0040, 32'h1234_0000, 4'b1100);
      send(F3_SB, 32'hFFFF_FFFF, 12'h001, 32'h0000_005A, 1, 32'h0000_0000, 32'h0000_005A, 4'b0001);
      send(F3_SB, 32'h0080, 12'h001, 32'h1122_3344, 1, 32'h0080, 32'h2233_4400, 4'b0010);
      send(F3_SW, 32'h0100, 12'hFFE, 32'h1, 2, 32'h00FE, 32'h0, 4'h0);
      wait_empty();

      // Fill the queue with memory stalled; fifth store must be held
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++)
         send(F3_SW, 32'h10 + 32'(4 * i), 12'h000, 32'hC0DE_0000 + 32'(i), 1,
              32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111);
      chk("full_ready", {31'b0, in_ready}, 32'd0);
      opcode = OPC_STORE;
      funct3 = F3_SW;
      rs1 = 32'h20;
      imm = 12'h000;
      rs2 = 32'hC0DE_0004;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("held_ready", {31'b0, in_ready}, 32'd0);
         chk("held_req", {31'b0, mem_req}, 32'd1);
         chk("held_addr", mem_addr, 32'h10);
      end
`ifdef STORE_FWD_EN
      ld_addr = 32'h1B;
      #1;
      chk("fwd_hit", {31'b0, ld_conflict}, 32'd1);
      ld_addr = 32'h44;
      #1;
      chk("fwd_miss", {31'b0, ld_conflict}, 32'd0);
`endif
      in_valid = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("ack_frees_slot", {31'b0, in_ready}, 32'd1);
      send(F3_SW, 32'h20, 12'h000, 32'hC0DE_0004, 1, 32'h20, 32'hC0DE_0004, 4'b1111);
      mem_ack = 1'b1;
      wait_empty();

      // Four queued stores drain on four consecutive cycles
      mem_ack = 1'b0;
      send(F3_SB, 32'h100, 12'h000, 32'h0000_0011, 1, 32'h100, 32'h0000_0011, 4'b0001);
      send(F3_SH, 32'h104, 12'h002, 32'h0000_BEEF, 1, 32'h104, 32'hBEEF_0000, 4'b1100);
      send(F3_SW, 32'h108, 12'h000, 32'h0102_0304, 1, 32'h108, 32'h0102_0304, 4'b1111);
      send(F3_SB, 32'h10C, 12'h001, 32'h0000_0077, 1, 32'h10C, 32'h0000_7700, 4'b0010);
      mem_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("burst_req", {31'b0, mem_req}, 32'd1);
      end
      tick();
      chk("burst_done_req", {31'b0, mem_req}, 32'd0);
      chk("burst_done_empty", {31'b0, empty}, 32'd1);

      // Asynchronous reset with a request outstanding
      mem_ack = 1'b0;
      send(F3_SW, 32'h500, 12'h000, 32'h99, 1, 32'h500, 32'h99, 4'b1111);
      tick();
      chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_req", {31'b0, mem_req}, 32'd0);
      chk("rst_async_empty", {31'b0, empty}, 32'd1);
      mq.delete();
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_req", {31'b0, mem_req}, 32'd0);
         chk("post_rst_empty", {31'b0, empty}, 32'd1);
      end
      mem_ack = 1'b0;

      chk("mem_left", 32'(mq.size()), 32'd0);
      chk("err_left", 32'(errq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
